// File: rtl/handshake_memory.sv
// Word-addressed unified memory serving level-based read/write requests with a
// programmable response latency and a four-phase request/response handshake.
module handshake_memory #(
  parameter int unsigned WORD_SIZE  = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 readM,
  input  logic                 writeM,
  input  logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  output logic                 inputReady,
  output logic                 ackOutput
);

  localparam int unsigned Depth   = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   op_wr_q, op_wr_d;
  logic [WORD_SIZE-1:0]   wdata_q, wdata_d;
  logic [WORD_SIZE-1:0]   rdata_q, rdata_d;
  logic                   ready_q, ready_d;
  logic                   ack_q, ack_d;
  logic                   mem_we;
  logic                   req_lvl;
  logic [WORD_SIZE-1:0]   mem_q [Depth];

  // Upper address bits are deliberately ignored (address wraps onto the array).
  logic unused_addr;
  assign unused_addr = ^(address >> ADDR_WIDTH);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    op_wr_d = op_wr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_d = ready_q;
    ack_d   = ack_q;
    mem_we  = 1'b0;
    // Only the level of the accepted operation keeps the transaction alive.
    req_lvl = op_wr_q ? writeM : readM;

    unique case (state_q)
      StIdle: begin
        if (readM || writeM) begin
          addr_d  = address[ADDR_WIDTH-1:0];
          op_wr_d = writeM;
          if (writeM) begin
            wdata_d = data;
          end
          cnt_d   = CntInit;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (!req_lvl) begin
          state_d = StIdle;
        end else if (cnt_q == 4'd0) begin
          state_d = StResp;
          if (op_wr_q) begin
            mem_we = 1'b1;
            ack_d  = 1'b1;
          end else begin
            rdata_d = mem_q[addr_q];
            ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (!req_lvl) begin
          ready_d = 1'b0;
          ack_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      op_wr_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      ack_q   <= 1'b0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      op_wr_q <= op_wr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      ack_q   <= ack_d;
      if (mem_we) begin
        mem_q[addr_q] <= wdata_q;
      end
    end
  end

  assign inputReady = ready_q;
  assign ackOutput  = ack_q;
  assign data       = (state_q == StResp && !op_wr_q) ? rdata_q : {WORD_SIZE{1'bz}};

endmodule

// File: doc/handshake_memory.md
Name: handshake_memory

Overview:
- Word-addressed unified instruction/data memory that sits directly downstream of the CPU datapath.
- It serves the datapath's level-based memory requests (readM/writeM, address, shared data bus).
- Completion is signalled with inputReady (read) or ackOutput (write) after a programmable latency.
- Each request is held until the datapath drops it, which closes a four-phase handshake.

Parameters:
- WORD_SIZE, 16, data and address bus width in bits.
- ADDR_WIDTH, 8, number of index bits; depth = 2^ADDR_WIDTH words.
- LATENCY, 2, cycles from request acceptance to response assertion; legal range is 1 to 15.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset_n  input  1  synchronous reset, active-high: a 1 sampled at a rising edge of clk resets the block.
- readM  input  1  read request level.
- writeM  input  1  write request level.
- address  input  WORD_SIZE  word address; only bits [ADDR_WIDTH-1:0] are used.
- data  inout  WORD_SIZE  read data driven by this block; write data driven by the datapath.
- inputReady  output  1  read data valid on data.
- ackOutput  output  1  write committed.

Behaviour:
- Reset: state=IDLE, inputReady=0, ackOutput=0, data released (high-Z), all memory words cleared to 0. Reset dominates any in-flight transaction; no write is committed on a reset edge.
- States: IDLE, BUSY, RESP. Outputs are registered; no combinational path from readM/writeM to inputReady/ackOutput.
- IDLE:
  - At an edge with readM|writeM=1: latch address[ADDR_WIDTH-1:0], latch op (write if writeM=1, else read), latch the data bus when op is write.
  - Load cnt=LATENCY-1 and go to BUSY.
  - If readM=writeM=1 at the same edge, the op is write (write priority); the read is ignored.
- BUSY:
  - Each edge: if the request level for the latched op is 0, abort to IDLE; no write is committed and no response is given.
  - Else if cnt=0: go to RESP. For a write, store the latched data to mem[addr] and set ackOutput=1. For a read, register mem[addr] into rdata and set inputReady=1.
  - Else cnt decrements.
- Timing: a request accepted at edge k gives a response visible after edge k+LATENCY. Example: with LATENCY=2, accept at edge 0, response after edge 2.
- RESP:
  - Hold inputReady/ackOutput while the request level stays 1.
  - At the first edge where it is 0: clear both outputs and go to IDLE.
  - A new request is accepted no earlier than the edge after that.
- data bus: driven with rdata only when state=RESP and op=read; high-Z otherwise, including during writes and reset.
- Address wrap: upper address bits are ignored; address 16'h0105 with ADDR_WIDTH=8 maps to word 5.
- Address/data changes after acceptance are ignored; latched values are used.
- inputReady and ackOutput are never 1 simultaneously.

Test Plan:
- Reset then read: assert reset_n=1 for 2 edges, then read address 16'h0003 -> inputReady rises after edge k+2, data=16'h0000; after readM drops, inputReady=0 one edge later and data=Z.
- Write/readback with LATENCY=2: write 16'hBEEF to 16'h0010 -> ackOutput after edge k+2. Drop writeM, then read 16'h0010 -> data=16'hBEEF.
- Back-to-back: write 16'h1234 at 16'h0001, then 16'h5678 at 16'h0002, then read both -> 16'h1234 and 16'h5678. Each new acceptance occurs only after the prior response deasserts.
- Abort and priority: drop readM mid-BUSY -> no inputReady, state IDLE. Raise readM=writeM=1 with data 16'h00AA at 16'h0004 -> ackOutput only, and a later read returns 16'h00AA.
- Wrap and reset mid-op: write 16'h7777 to 16'h0105, read 16'h0005 -> 16'h7777. Assert reset_n in BUSY of a write to 16'h0006 -> outputs 0 next edge, and a read of 16'h0006 returns 16'h0000.
- LATENCY=1 instance: response visible exactly one edge after acceptance.
